// File: rtl/load_store_unit.sv
// load_store_unit: bridges core loads/stores to a byte-addressable data memory, splitting
// misaligned half/word accesses into byte beats. Optional macro LSU_SPLIT_CNT_EN adds split_cnt.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_R,
    input  logic        mem_W,
    input  logic [31:0] addr,
    input  logic [2:0]  RW_type,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        dm_R_en,
    output logic        dm_W_en,
    output logic [31:0] dm_addr,
    output logic [2:0]  dm_RW_type,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
`ifdef LSU_SPLIT_CNT_EN
    ,
    output logic [31:0] split_cnt
`endif
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned BEAT_W = 2;
    localparam int unsigned LANE_W = 5;

    typedef enum logic [1:0] {IDLE, LATCH, SPLIT, DONE} state_t;

    state_t              state, next_state;
    logic [XLEN-1:0]     addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [XLEN-1:0]     asm_q;
    logic                word_q;
    logic                zext_q;
    logic                store_q;
    logic [BEAT_W-1:0]   beat_q;

    logic                req_c;
    logic                misaligned_c;
    logic                latch_en_c;
    logic                last_beat_c;
    logic [LANE_W-1:0]   lane_c;
    logic [XLEN-1:0]     done_data_c;

    assign req_c        = mem_R | mem_W;
    assign misaligned_c = ((RW_type[1:0] == 2'b01) && addr[0]) ||
                          (RW_type[1] && (addr[1:0] != 2'b00));
    assign last_beat_c  = (beat_q == (word_q ? 2'd3 : 2'd1));
    assign lane_c       = {beat_q, 3'b000};

    // Final load value: words pass as assembled, halves extend from bit 15
    always_comb begin
        done_data_c = asm_q;
        if (!word_q) begin
            if (zext_q) done_data_c = {16'h0000, asm_q[15:0]};
            else        done_data_c = {{16{asm_q[15]}}, asm_q[15:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        dm_R_en    = 1'b0;
        dm_W_en    = 1'b0;
        dm_addr    = addr;
        dm_RW_type = RW_type;
        dm_din     = wdata;
        rdata      = '0;
        latch_en_c = 1'b0;
        case (state)
            IDLE: begin
                // Held in reset: no memory traffic and no stall
                if (!rst_n) begin
                    next_state = IDLE;
                end else if (req_c && misaligned_c) begin
                    stall      = 1'b1;
                    latch_en_c = 1'b1;
                    next_state = LATCH;
                end else begin
                    dm_R_en = mem_R & ~mem_W;
                    dm_W_en = mem_W;
                    rdata   = (mem_R & mem_W) ? '0 : dm_dout;
                end
            end
            LATCH: begin
                stall      = 1'b1;
                next_state = SPLIT;
            end
            SPLIT: begin
                stall      = 1'b1;
                dm_addr    = addr_q + XLEN'(beat_q);
                dm_RW_type = store_q ? 3'b000 : 3'b100;
                dm_din     = {24'h000000, wdata_q[lane_c +: 8]};
                dm_R_en    = ~store_q;
                dm_W_en    = store_q;
                if (last_beat_c) next_state = DONE;
            end
            DONE: begin
                rdata      = done_data_c;
                next_state = IDLE;
            end
        endcase
    end

    // Request latch, beat counter and little-endian load assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            word_q  <= 1'b0;
            zext_q  <= 1'b0;
            store_q <= 1'b0;
            beat_q  <= '0;
        end else if (latch_en_c) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            asm_q   <= '0;
            word_q  <= RW_type[1];
            zext_q  <= RW_type[2];
            store_q <= mem_W;
            beat_q  <= '0;
        end else if (state == SPLIT) begin
            beat_q <= beat_q + 2'd1;
            if (!store_q) asm_q[lane_c +: 8] <= dm_dout[7:0];
        end
    end

`ifdef LSU_SPLIT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               split_cnt <= '0;
        else if (latch_en_c && (split_cnt != '1)) split_cnt <= split_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a byte-level
// reference model; the bench also provides the data memory.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_R;
    logic        mem_W;
    logic [31:0] addr;
    logic [2:0]  RW_type;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        dm_R_en;
    logic        dm_W_en;
    logic [31:0] dm_addr;
    logic [2:0]  dm_RW_type;
    logic [31:0] dm_din;
    logic [31:0] dm_dout;
`ifdef LSU_SPLIT_CNT_EN
    logic [31:0] split_cnt;
`endif

    int n_checks;
    int n_err;
    int n_split;

    logic [7:0]  mem     [256] = '{default: 8'h00};
    logic [7:0]  ref_mem [256] = '{default: 8'h00};
    logic [31:0] beat_q[$];

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_R      (mem_R),
        .mem_W      (mem_W),
        .addr       (addr),
        .RW_type    (RW_type),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .dm_R_en    (dm_R_en),
        .dm_W_en    (dm_W_en),
        .dm_addr    (dm_addr),
        .dm_RW_type (dm_RW_type),
        .dm_din     (dm_din),
        .dm_dout    (dm_dout)
`ifdef LSU_SPLIT_CNT_EN
        ,
        .split_cnt  (split_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational extended read, byte-lane write at the clock edge
    always_comb begin
        logic [31:0] raw;
        raw = {mem[8'(dm_addr[7:0] + 8'd3)], mem[8'(dm_addr[7:0] + 8'd2)],
               mem[8'(dm_addr[7:0] + 8'd1)], mem[dm_addr[7:0]]};
        if (dm_RW_type[1])      dm_dout = raw;
        else if (dm_RW_type[0]) dm_dout = dm_RW_type[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
        else                    dm_dout = dm_RW_type[2] ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
    end

    always @(posedge clk) begin
        if (dm_W_en) begin
            mem[dm_addr[7:0]] <= dm_din[7:0];
            if (dm_RW_type[1:0] != 2'b00) mem[8'(dm_addr[7:0] + 8'd1)] <= dm_din[15:8];
            if (dm_RW_type[1]) begin
                mem[8'(dm_addr[7:0] + 8'd2)] <= dm_din[23:16];
                mem[8'(dm_addr[7:0] + 8'd3)] <= dm_din[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] t);
        return t[1] ? 4 : (t[0] ? 2 : 1);
    endfunction

    // Reference: whole-access semantics in bytes; latency is beats plus one latch cycle
    task automatic ref_access(input logic r, input logic w, input logic [31:0] a,
                              input logic [2:0] t, input logic [31:0] d,
                              output logic [31:0] exp_rd, output int exp_stall);
        int n;
        longint unsigned v;
        n = size_of(t);
        v = 0;
        exp_stall = ((a % 32'(n)) != 0) ? n + 1 : 0;
        if (w) begin
            exp_rd = 32'h0;
            for (int k = 0; k < n; k++) ref_mem[8'(a + 32'(k))] = d[8*k +: 8];
        end else begin
            for (int k = 0; k < n; k++) v = v | (longint'(ref_mem[8'(a + 32'(k))]) << (8*k));
            if (!t[2] && n < 4 && v[8*n-1]) v = v | (64'hFFFF_FFFF << (8*n));
            exp_rd = v[31:0];
        end
        if (!r && !w) exp_rd = 32'h0;
    endtask

    // Drive one request from one cycle after an edge; returns result and stall-cycle count
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [2:0] t, input logic [31:0] d,
                          output logic [31:0] rd, output int stalls);
        mem_R = r; mem_W = w; addr = a; RW_type = t; wdata = d;
        beat_q.delete();
        stalls = 0;
        #1;
        if (!stall) begin
            rd = rdata;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            while (stall && stalls < 20) begin
                stalls++;
                if (dm_R_en || dm_W_en) beat_q.push_back(dm_addr);
                @(posedge clk); #1;
            end
            rd = rdata;
            @(posedge clk); #1;
        end
        mem_R = 1'b0;
        mem_W = 1'b0;
    endtask

    task automatic xact(input string tag, input logic r, input logic w, input logic [31:0] a,
                        input logic [2:0] t, input logic [31:0] d, output logic [31:0] rd);
        logic [31:0] exp_rd;
        int exp_stall;
        int stalls;
        int n;
        ref_access(r, w, a, t, d, exp_rd, exp_stall);
        access(r, w, a, t, d, rd, stalls);
        check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
        if (r) check({tag, " rdata"}, rd, exp_rd);
        if (exp_stall != 0) begin
            n_split++;
            n = size_of(t);
            check({tag, " beats"}, 32'(beat_q.size()), 32'(n));
            for (int k = 0; k < beat_q.size() && k < n; k++)
                check({tag, " beat_addr"}, beat_q[k], a + 32'(k));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_rd;
        int          exp_stall;
        logic        r;
        logic        w;
        logic [2:0]  t;
        logic [31:0] a;
        int          op;

        n_checks = 0; n_err = 0; n_split = 0;
        rst_n = 1'b0; mem_R = 1'b0; mem_W = 1'b0;
        addr = '0; RW_type = '0; wdata = '0;
        #12;
        check("reset stall", 32'(stall), 32'd0);
        check("reset dm_W_en", 32'(dm_W_en), 32'd0);
        check("reset dm_R_en", 32'(dm_R_en), 32'd0);
        check("reset rdata", rdata, 32'h0);
`ifdef LSU_SPLIT_CNT_EN
        check("reset split_cnt", split_cnt, 32'h0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Aligned word store passes through in the same cycle
        mem_W = 1'b1; addr = 32'h10; RW_type = 3'b010; wdata = 32'hDEADBEEF;
        #1;
        check("st10 dm_W_en", 32'(dm_W_en), 32'd1);
        check("st10 dm_addr", dm_addr, 32'h10);
        check("st10 dm_din", dm_din, 32'hDEADBEEF);
        check("st10 stall", 32'(stall), 32'd0);
        ref_access(1'b0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, exp_rd, exp_stall);
        @(posedge clk); #1;
        mem_W = 1'b0;
        xact("ld10", 1'b1, 1'b0, 32'h10, 3'b010, 32'h0, rd);
        check("ld10 value", rd, 32'hDEADBEEF);

        // Misaligned word store split into four byte beats
        xact("st21", 1'b0, 1'b1, 32'h21, 3'b010, 32'h11223344, rd);
        xact("ld20", 1'b1, 1'b0, 32'h20, 3'b010, 32'h0, rd);
        check("ld20 value", rd, 32'h22334400);
        xact("ld24", 1'b1, 1'b0, 32'h24, 3'b010, 32'h0, rd);
        check("ld24 value", rd, 32'h00000011);

        // Misaligned half loads, signed and unsigned
        xact("stb13", 1'b0, 1'b1, 32'h13, 3'b000, 32'h00000080, rd);
        xact("stb14", 1'b0, 1'b1, 32'h14, 3'b000, 32'h000000FF, rd);
        xact("ldh13s", 1'b1, 1'b0, 32'h13, 3'b001, 32'h0, rd);
        check("ldh13s value", rd, 32'hFFFFFF80);
        xact("ldh13u", 1'b1, 1'b0, 32'h13, 3'b101, 32'h0, rd);
        check("ldh13u value", rd, 32'h0000FF80);

        // Address wrap across 2^32
        xact("ldwrap", 1'b1, 1'b0, 32'hFFFFFFFF, 3'b010, 32'h0, rd);

        // Load and store together act as a store with rdata 0
        xact("both", 1'b1, 1'b1, 32'h30, 3'b010, 32'hCAFEF00D, rd);
        xact("both_mis", 1'b1, 1'b1, 32'h33, 3'b001, 32'h0000BEEF, rd);

        // Reset during beat 1 of a misaligned word store at 0x01
        xact("pre0", 1'b0, 1'b1, 32'h00, 3'b010, 32'hA5A5A5A5, rd);
        xact("pre4", 1'b0, 1'b1, 32'h04, 3'b010, 32'h5A5A5A5A, rd);
        mem_W = 1'b1; addr = 32'h01; RW_type = 3'b010; wdata = 32'h11223344;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst beat1 addr", dm_addr, 32'h02);
        check("rst beat1 din", dm_din, 32'h00000033);
        rst_n = 1'b0; mem_W = 1'b0;
        #1;
        check("rst stall", 32'(stall), 32'd0);
        check("rst dm_W_en", 32'(dm_W_en), 32'd0);
`ifdef LSU_SPLIT_CNT_EN
        check("rst split_cnt", split_cnt, 32'h0);
`endif
        n_split = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ref_mem[1] = 8'h44;
        @(posedge clk); #1;
        xact("post_rst0", 1'b1, 1'b0, 32'h00, 3'b010, 32'h0, rd);
        check("post_rst0 value", rd, 32'hA5A544A5);
        xact("post_rst4", 1'b1, 1'b0, 32'h04, 3'b010, 32'h0, rd);
        check("post_rst4 value", rd, 32'h5A5A5A5A);
        xact("post_rst_h3", 1'b1, 1'b0, 32'h03, 3'b001, 32'h0, rd);

        // Randomized mix of loads, stores and combined requests
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 2));
            r  = (op != 1);
            w  = (op != 0);
            t  = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                             : 32'h40 + 32'($urandom_range(0, 63));
            xact("rand", r, w, a, t, $urandom, rd);
        end

        for (int i = 0; i < 256; i++) check("mem_byte", 32'(mem[i]), 32'(ref_mem[i]));
`ifdef LSU_SPLIT_CNT_EN
        check("split_cnt", split_cnt, 32'(n_split));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mem_R  input  1  load request from core, held until stall=0.
REQ-005 mem_W  input  1  store request from core, held until stall=0.
REQ-006 addr  input  32  byte address of access.
REQ-007 RW_type  input  3  [1:0] 00=byte, 01=half, 10/11=word; [2] 1=zero-extend load, 0=sign-extend.
REQ-008 wdata  input  32  store data, LSB-aligned.
REQ-009 rdata  output  32  extended load result to core.
REQ-010 stall  output  1  core must hold PC and request while high.
REQ-011 dm_R_en, dm_W_en  output  1 each  data-memory read and write enables.
REQ-012 dm_addr  output  32; dm_RW_type  output  3; dm_din  output  32  data-memory access fields, same encodings as addr/RW_type/wdata.
REQ-013 dm_dout  input  32  data-memory combinational read data.

Function
REQ-014 Misaligned SHALL mean: half with addr[0]=1, or word with addr[1:0]!=00; bytes are never misaligned.
REQ-015 Active request SHALL mean mem_R|mem_W; both asserted is treated as a store, with rdata=0.
REQ-016 FSM states SHALL be IDLE, LATCH, SPLIT, DONE.
REQ-017 IDLE, aligned or no request: pure combinational pass-through: dm_* = core fields, rdata=dm_dout, stall=0, zero latency.
REQ-018 IDLE, misaligned request: stall=1, dm_R_en=dm_W_en=0; latch addr, RW_type, wdata, op; next state LATCH, beat counter=0.
REQ-019 LATCH: stall=1, no memory op; next state SPLIT.
REQ-020 SPLIT: one byte access per cycle, dm_addr=latched addr+beat (32-bit wrap mod 2^32), dm_RW_type=100 for loads and 000 for stores, dm_din={24'h0, wdata[8*beat+7:8*beat]}, stall=1.
REQ-021 SPLIT load: dm_dout[7:0] captured into assembly bits [8*beat+7:8*beat] (little-endian) at the clock edge.
REQ-022 Beat count SHALL be 2 for half and 4 for word; after the last beat, next state DONE.
REQ-023 DONE: stall=0, no memory op, rdata=assembled value sign- or zero-extended per latched RW_type[2] (half: bit 15; word: none); next state IDLE unconditionally.
REQ-024 Latency, measured as cycles with stall=1: misaligned half 3, misaligned word 5; memory writes occur only at SPLIT-cycle edges.
REQ-025 Core inputs SHALL be ignored outside IDLE; latched values alone drive SPLIT/DONE.
REQ-026 rdata SHALL be 0 in LATCH and SPLIT.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, beat=0, and latches/assembly=0; outputs then follow IDLE pass-through (stall=0).
REQ-028 Reset mid-SPLIT SHALL abort the access; completed byte writes remain, and no further writes occur.

Configuration
REQ-029 Macro LSU_SPLIT_CNT_EN: when defined, add output split_cnt[31:0], reset 0, incremented on each IDLE->LATCH transition, saturating at 32'hFFFFFFFF.
REQ-030 Without LSU_SPLIT_CNT_EN: no split_cnt port or counter logic; all other behaviour identical.

Verification
REQ-031 Aligned word store addr=0x10, wdata=0xDEADBEEF -> same-cycle dm_W_en=1, dm_addr=0x10, stall=0; later aligned load returns 0xDEADBEEF.
REQ-032 Store word 0x11223344 at 0x21 -> stall 5 cycles; beats write 0x44@0x21, 0x33@0x22, 0x22@0x23, 0x11@0x24; aligned words 0x20/0x24 updated accordingly.
REQ-033 Memory bytes 0x80@0x13, 0xFF@0x14; load half signed at 0x13 -> DONE rdata=0xFFFFFF80 (assembled 0xFF80); unsigned -> 0x0000FF80.
REQ-034 Misaligned word load at 0xFFFFFFFF -> beat addresses 0xFFFFFFFF, 0x0, 0x1, 0x2 (wrap), stall=1 for 5 cycles, then DONE.
REQ-035 rst_n pulsed low during beat 1 of a word store at 0x01 -> stall=0 immediately, only byte 0x01 written, next request handled from IDLE.
REQ-036 LSU_SPLIT_CNT_EN defined: three misaligned and two aligned accesses -> split_cnt=3; reset -> 0.
